// File: rtl/soc_system_clkgen_bank.sv
// soc_system_clkgen_bank: run-time programmable bank of clock-enable generators with shadow/apply config and lock indication.
// Optional feature: define CLKGEN_PHASE_EN to add per-channel PHASE registers (phase-offset restart).
module soc_system_clkgen_bank #(
  parameter int NUM_CLOCKS  = 4,
  parameter int CNT_W       = 16,
  parameter int ADDR_W      = 6,
  parameter int DEFAULT_DIV = 4,
  parameter int LOCK_CYCLES = 256
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [CNT_W-1:0]      wdata,
  output logic [CNT_W-1:0]      rdata,
  output logic                  rvalid,
  input  logic                  apply,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] ce,
  output logic                  locked,
  output logic                  busy
);
  localparam int LW = $clog2(LOCK_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEFAULT_DIV / 2);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic init_q, init_d, restart;
  logic [ADDR_W-3:0] ch;
  logic [1:0] rs;
  int ch_i;
  logic [CNT_W-1:0] div_s_q [NUM_CLOCKS];
  logic [CNT_W-1:0] div_s_d [NUM_CLOCKS];
  logic [CNT_W-1:0] high_s_q [NUM_CLOCKS];
  logic [CNT_W-1:0] high_s_d [NUM_CLOCKS];
`ifdef CLKGEN_PHASE_EN
  logic [CNT_W-1:0] phase_s_q [NUM_CLOCKS];
  logic [CNT_W-1:0] phase_s_d [NUM_CLOCKS];
  logic [CNT_W-1:0] san_p [NUM_CLOCKS];
`endif
  logic [CNT_W-1:0] div_a_q [NUM_CLOCKS];
  logic [CNT_W-1:0] div_a_d [NUM_CLOCKS];
  logic [CNT_W-1:0] high_a_q [NUM_CLOCKS];
  logic [CNT_W-1:0] high_a_d [NUM_CLOCKS];
  logic [CNT_W-1:0] cnt_q [NUM_CLOCKS];
  logic [CNT_W-1:0] cnt_d [NUM_CLOCKS];
  logic [CNT_W-1:0] san_n [NUM_CLOCKS];
  logic [CNT_W-1:0] san_h [NUM_CLOCKS];
  logic [CNT_W-1:0] start [NUM_CLOCKS];
  logic [CNT_W-1:0] ph_v [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] outclk_q, outclk_d, ce_q, ce_d;
  logic [CNT_W-1:0] rdata_q, rdata_d;
  logic rvalid_q, rvalid_d;

  assign ch = addr[ADDR_W-1:2];
  assign rs = addr[1:0];
  assign ch_i = 32'(ch);
  assign restart = apply | init_q;
  assign outclk = outclk_q;
  assign ce = ce_q;
  assign rdata = rdata_q;
  assign rvalid = rvalid_q;

  // Sanitise shadow config into the values an apply would load, plus each channel's counter start value.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      san_n[i] = (div_s_q[i] < CNT_W'(2)) ? CNT_W'(2) : div_s_q[i];
      san_h[i] = (high_s_q[i] == '0 || high_s_q[i] >= san_n[i]) ? (san_n[i] >> 1) : high_s_q[i];
`ifdef CLKGEN_PHASE_EN
      san_p[i] = phase_s_q[i] % san_n[i];
      start[i] = (san_p[i] == '0) ? '0 : san_n[i] - san_p[i];
      ph_v[i] = phase_s_q[i];
`else
      start[i] = '0;
      ph_v[i] = '0;
`endif
    end
  end

  // Shadow writes, restart loading of active config, channel counters and registered outputs.
  always_comb begin
    div_s_d = div_s_q;
    high_s_d = high_s_q;
`ifdef CLKGEN_PHASE_EN
    phase_s_d = phase_s_q;
`endif
    div_a_d = div_a_q;
    high_a_d = high_a_q;
    cnt_d = cnt_q;
    outclk_d = '0;
    ce_d = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (wr && ch_i == i && rs == 2'd0) div_s_d[i] = wdata;
      if (wr && ch_i == i && rs == 2'd1) high_s_d[i] = wdata;
`ifdef CLKGEN_PHASE_EN
      if (wr && ch_i == i && rs == 2'd2) phase_s_d[i] = wdata;
`endif
      div_a_d[i] = restart ? san_n[i] : div_a_q[i];
      high_a_d[i] = restart ? san_h[i] : high_a_q[i];
      cnt_d[i] = restart ? start[i] : (cnt_q[i] >= div_a_q[i] - 1'b1) ? '0 : cnt_q[i] + 1'b1;
      outclk_d[i] = !restart && (cnt_q[i] < high_a_q[i]);
      ce_d[i] = !restart && (cnt_q[i] == '0);
    end
  end

  // Register read path: shadow values (pre-write), status for reg 3, zero for absent channels.
  always_comb begin
    rdata_d = rdata_q;
    rvalid_d = rd;
    if (rd) rdata_d = '0;
    for (int i = 0; i < NUM_CLOCKS; i++)
      if (rd && ch_i == i)
        rdata_d = rs == 2'd0 ? div_s_q[i] : rs == 2'd1 ? high_s_q[i] : rs == 2'd2 ? ph_v[i] : CNT_W'(locked);
  end

  // Datapath registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_s_q[i] <= DEF_N;
        high_s_q[i] <= DEF_H;
`ifdef CLKGEN_PHASE_EN
        phase_s_q[i] <= '0;
`endif
        div_a_q[i] <= DEF_N;
        high_a_q[i] <= DEF_H;
        cnt_q[i] <= '0;
      end
      outclk_q <= '0;
      ce_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      init_q <= 1'b1;
    end else begin
      div_s_q <= div_s_d;
      high_s_q <= high_s_d;
`ifdef CLKGEN_PHASE_EN
      phase_s_q <= phase_s_d;
`endif
      div_a_q <= div_a_d;
      high_a_q <= high_a_d;
      cnt_q <= cnt_d;
      outclk_q <= outclk_d;
      ce_q <= ce_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      init_q <= init_d;
    end
  end

  assign init_d = 1'b0;

  // Lock FSM state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= UNLOCKED;
      lock_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Lock FSM next state: any restart drops lock, then count LOCK_CYCLES edges before locking.
  always_comb begin
    state_d = state_q;
    lock_cnt_d = lock_cnt_q;
    if (restart) begin
      state_d = UNLOCKED;
      lock_cnt_d = '0;
    end else if (state_q == UNLOCKED) begin
      state_d = (lock_cnt_q == LOCK_LAST) ? LOCKED : UNLOCKED;
      lock_cnt_d = (&lock_cnt_q) ? lock_cnt_q : lock_cnt_q + 1'b1;
    end
  end

  // Lock FSM outputs.
  always_comb begin
    locked = (state_q == LOCKED);
    busy = !locked;
  end
endmodule

// File: tb/tb_soc_system_clkgen_bank.sv
// tb_soc_system_clkgen_bank: directed bench with an edge-indexed behavioural model of the clock-enable bank.
module tb_soc_system_clkgen_bank;
  localparam int NC = 4;
  localparam int CW = 16;
  localparam int AW = 6;
  localparam int L = 256;
  logic refclk, rst, wr, rd, apply;
  logic [AW-1:0] addr;
  logic [CW-1:0] wdata, rdata;
  logic rvalid, locked, busy;
  logic [NC-1:0] outclk, ce;
  int errors = 0;
  int checks = 0;

  soc_system_clkgen_bank #(.NUM_CLOCKS(NC), .CNT_W(CW), .ADDR_W(AW), .DEFAULT_DIV(4), .LOCK_CYCLES(L)) dut (
    .refclk(refclk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .rdata(rdata),
    .rvalid(rvalid), .apply(apply), .outclk(outclk), .ce(ce), .locked(locked), .busy(busy));

  initial begin
    refclk = 0;
    forever #5 refclk = ~refclk;
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, e);
    end
  endtask

  // Model: edge index of the last restart plus sanitised active config; outputs follow from arithmetic on edge distance.
  int sh_div [NC], sh_high [NC], sh_ph [NC];
  int a_n [NC], a_h [NC], a_p [NC];
  int edge_n, rk, exp_rdata;
  bit act, init_p, exp_rvalid;

  function automatic bit m_locked();
    return act && (edge_n - rk) >= L;
  endfunction

  function automatic int m_reg(input int c, input int r);
    if (c >= NC) return 0;
    case (r)
      0: return sh_div[c];
      1: return sh_high[c];
`ifdef CLKGEN_PHASE_EN
      2: return sh_ph[c];
`else
      2: return 0;
`endif
      default: return int'(m_locked());
    endcase
  endfunction

  initial forever begin
    int c, r, n;
    @(posedge refclk or posedge rst);
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        sh_div[i] = 4; sh_high[i] = 2; sh_ph[i] = 0;
        a_n[i] = 4; a_h[i] = 2; a_p[i] = 0;
      end
      edge_n = -1; rk = 0; act = 0; init_p = 1; exp_rdata = 0; exp_rvalid = 0;
    end else begin
      c = int'(addr) / 4;
      r = int'(addr) % 4;
      exp_rvalid = rd;
      if (rd) exp_rdata = m_reg(c, r);
      edge_n++;
      if (init_p || apply) begin
        for (int i = 0; i < NC; i++) begin
          n = sh_div[i] < 2 ? 2 : sh_div[i];
          a_n[i] = n;
          a_h[i] = (sh_high[i] == 0 || sh_high[i] >= n) ? n / 2 : sh_high[i];
`ifdef CLKGEN_PHASE_EN
          a_p[i] = sh_ph[i] % n;
`else
          a_p[i] = 0;
`endif
        end
        rk = edge_n; act = 1; init_p = 0;
      end
      if (wr && c < NC) begin
        if (r == 0) sh_div[c] = int'(wdata);
        if (r == 1) sh_high[c] = int'(wdata);
        if (r == 2) sh_ph[c] = int'(wdata);
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial forever begin
    logic [NC-1:0] eo, ec;
    int d, pos;
    @(negedge refclk);
    eo = '0; ec = '0;
    for (int i = 0; i < NC; i++)
      if (act && edge_n != rk) begin
        d = edge_n - 1 - rk;
        pos = (d + a_n[i] - a_p[i]) % a_n[i];
        eo[i] = pos < a_h[i];
        ec[i] = pos == 0;
      end
    chk("m_outclk", 32'(outclk), 32'(eo));
    chk("m_ce", 32'(ce), 32'(ec));
    chk("m_locked", 32'(locked), 32'(m_locked()));
    chk("m_busy", 32'(busy), 32'(!m_locked()));
    chk("m_rvalid", 32'(rvalid), 32'(exp_rvalid));
    chk("m_rdata", 32'(rdata), 32'(exp_rdata));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic do_write(input int c, input int r, input int v);
    wr = 1; addr = AW'(c * 4 + r); wdata = CW'(v);
    @(negedge refclk);
    wr = 0;
  endtask

  task automatic do_apply();
    apply = 1;
    @(negedge refclk);
    apply = 0;
  endtask

  task automatic do_read(input string nm, input int c, input int r, input int e);
    rd = 1; addr = AW'(c * 4 + r);
    @(negedge refclk);
    rd = 0;
    chk({nm, "_rvalid"}, 32'(rvalid), 1);
    chk(nm, 32'(rdata), 32'(e));
  endtask

  initial begin
    rst = 1; wr = 0; rd = 0; apply = 0; addr = '0; wdata = '0;
    tick(3);
    chk("rst_outclk", 32'(outclk), 0);
    chk("rst_busy", 32'(busy), 1);
    rst = 0;
    tick(1);
    chk("e0_ce", 32'(ce), 0);
    tick(1);
    chk("e1_ce", 32'(ce), 32'hF);
    chk("e1_out", 32'(outclk), 32'hF);
    tick(1);
    chk("e2_out", 32'(outclk), 32'hF);
    tick(1);
    chk("e3_out", 32'(outclk), 0);
    tick(2);
    chk("e5_ce", 32'(ce), 32'hF);
    tick(250);
    chk("e255_locked", 32'(locked), 0);
    tick(1);
    chk("e256_locked", 32'(locked), 1);
    // ch1 N=10 H=3
    do_write(1, 0, 10);
    do_write(1, 1, 3);
    do_apply();
    chk("ap_locked", 32'(locked), 0);
    tick(1);
    chk("ap1_ce", 32'(ce), 32'hF);
    tick(2);
    chk("ap3_out1", 32'(outclk[1]), 1);
    tick(1);
    chk("ap4_out1", 32'(outclk[1]), 0);
    tick(7);
    chk("ap11_ce1", 32'(ce[1]), 1);
    tick(244);
    chk("ap255_locked", 32'(locked), 0);
    tick(1);
    chk("ap256_locked", 32'(locked), 1);
    // invalid config on ch0, register access corner cases
    do_write(0, 0, 1);
    do_write(0, 1, 0);
    do_apply();
    tick(1);
    chk("inv1_out0", 32'(outclk[0]), 1);
    tick(1);
    chk("inv2_out0", 32'(outclk[0]), 0);
    tick(1);
    chk("inv3_out0", 32'(outclk[0]), 1);
    do_read("rd_div0_raw", 0, 0, 1);
    tick(1);
    chk("rvalid_pulse", 32'(rvalid), 0);
    do_read("rd_high1", 1, 1, 3);
    do_write(5, 0, 7);
    do_read("rd_bad_ch", 5, 0, 0);
    do_write(1, 3, 16'hFFFF);
    do_read("rd_status", 1, 3, 0);
    wr = 1; rd = 1; addr = AW'(3 * 4); wdata = 6;
    tick(1);
    wr = 0; rd = 0;
    chk("rdwr_pre", 32'(rdata), 4);
    do_read("rdwr_post", 3, 0, 6);
    do_write(2, 2, 5);
`ifdef CLKGEN_PHASE_EN
    do_read("rd_phase2", 2, 2, 5);
`else
    do_read("rd_phase2", 2, 2, 0);
`endif
    // relock with a write coincident with apply, then re-apply mid-relock
    tick(260);
    chk("pre_locked", 32'(locked), 1);
    wr = 1; addr = AW'(3 * 4); wdata = 12;
    do_apply();
    wr = 0;
    chk("ra_locked", 32'(locked), 0);
    tick(7);
    chk("ra7_ce3", 32'(ce[3]), 1);
    tick(92);
    do_apply();
    tick(7);
    chk("rb7_ce3", 32'(ce[3]), 0);
    tick(6);
    chk("rb13_ce3", 32'(ce[3]), 1);
    tick(242);
    chk("rb255_locked", 32'(locked), 0);
    tick(1);
    chk("rb256_locked", 32'(locked), 1);
    // phase offset on ch2 against ch0
    do_write(0, 0, 8);
    do_write(0, 2, 0);
    do_write(2, 0, 8);
    do_write(2, 2, 3);
    for (int k = 0; k < 2; k++) begin
      do_apply();
      tick(1);
      chk("ph1_ce0", 32'(ce[0]), 1);
`ifdef CLKGEN_PHASE_EN
      chk("ph1_ce2", 32'(ce[2]), 0);
      tick(3);
      chk("ph4_ce2", 32'(ce[2]), 1);
`else
      chk("ph1_ce2", 32'(ce[2]), 1);
      tick(3);
      chk("ph4_ce2", 32'(ce[2]), 0);
`endif
      do_write(2, 2, 11);
    end
    // asynchronous reset mid-period
    tick(260);
    chk("ar_pre_locked", 32'(locked), 1);
    @(posedge refclk);
    #2 rst = 1;
    #1;
    chk("ar_outclk", 32'(outclk), 0);
    chk("ar_ce", 32'(ce), 0);
    chk("ar_locked", 32'(locked), 0);
    chk("ar_busy", 32'(busy), 1);
    tick(2);
    rst = 0;
    do_read("ar_div1", 1, 0, 4);
    do_read("ar_high0", 0, 1, 2);
    do_read("ar_phase2", 2, 2, 0);
    tick(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/soc_system_clkgen_bank.md
Name: soc_system_clkgen_bank

Overview:
- Parametrised, run-time programmable bank of NUM_CLOCKS clock-enable generators. Everything runs on one reference clock.
- Each channel has a programmable period, high time and (optionally) phase offset. Each produces:
  - a registered divided square wave;
  - a one-cycle clock-enable pulse.
- Sits beside the fixed-ratio PLL wrapper. Peripherals needing slow, reconfigurable rates (pixel/sensor/ADC strobes) use it instead of extra PLL outputs.
- Provides a shadow/apply register interface and a locked indication, mirroring the PLL's locked semantics.

Parameters:
- NUM_CLOCKS, 4, number of output channels (1..16).
- CNT_W, 16, counter/config width per channel.
- ADDR_W, 6, register address width; 2^(ADDR_W-2) must be >= NUM_CLOCKS.
- DEFAULT_DIV, 4, reset period for every channel (>= 2).
- LOCK_CYCLES, 256, refclk cycles after restart before locked asserts (>= 1).

Ports:
- refclk  in  1  sole clock.
- rst  in  1  asynchronous active-high reset.
- wr  in  1  register write strobe.
- rd  in  1  register read strobe.
- addr  in  ADDR_W  {channel, reg[1:0]}.
- wdata  in  CNT_W  write data.
- rdata  out  CNT_W  read data, registered.
- rvalid  out  1  read data valid.
- apply  in  1  copy all shadow regs to active, restart all channels aligned.
- outclk  out  NUM_CLOCKS  divided square waves.
- ce  out  NUM_CLOCKS  one-cycle enable at each outclk rising edge.
- locked  out  1  outputs stable for LOCK_CYCLES since last restart.
- busy  out  1  high whenever locked is low.

Behaviour:
- Reset and clock: one clock (refclk); reset rst is asynchronous and active-high.
- Reset values, applied immediately on rst:
  - shadow and active DIV = DEFAULT_DIV; HIGH = DEFAULT_DIV/2; PHASE = 0;
  - counters = 0; outclk = 0; ce = 0; rdata = 0; rvalid = 0; locked = 0; busy = 1; lock counter = 0.
- First restart is implicit on the first edge after rst deasserts. Behaviour is then as if apply were sampled on that edge.
- Register map, per channel c = addr[ADDR_W-1:2]:
  - reg 0 = DIV (period N);
  - reg 1 = HIGH (H);
  - reg 2 = PHASE (P);
  - reg 3 = status, read-only: bit0 = locked, other bits 0.
- Writes and reads:
  - Writes update shadow regs only.
  - Writes with c >= NUM_CLOCKS, or to reg 3, are ignored.
  - Read: rd at edge k gives rdata = shadow value and rvalid = 1 at edge k+1 (one-cycle pulse). Invalid c returns 0.
  - wr and rd in the same cycle: both are performed; rdata returns the pre-write value.
- Sanitisation, applied when shadow is copied to active (shadow keeps the raw value):
  - N < 2 → N = 2;
  - H == 0 or H >= N → H = N >> 1;
  - P >= N → P = P mod N.
- FSM:
  - States: UNLOCKED, LOCKED.
  - Restart occurs on apply, or on the first edge after reset. At the restart edge k:
    - active regs load from sanitised shadow;
    - all channel counters load their start value;
    - lock counter = 0; locked = 0; state = UNLOCKED.
  - A write in the same cycle as apply lands in shadow but is NOT applied.
  - apply in any state, including repeated every cycle, restarts; locked stays 0.
  - UNLOCKED → LOCKED when the lock counter reaches LOCK_CYCLES-1, so locked = 1 from edge k+LOCK_CYCLES.
- Channel operation:
  - Each counter counts 0..N-1 and wraps to 0.
  - outclk[i] is registered as (counter < H) and lags the counter by one cycle.
  - ce[i] is registered as (counter == 0).
  - Without phase offset: after restart at edge k, ce pulses at edge k+1, k+1+N, ...; outclk is high for H cycles from edge k+1, then low for N-H cycles.
  - All channels restart on the same edge, so equal-N channels are edge-aligned.
- Width rules:
  - counter comparisons are unsigned, CNT_W wide;
  - lock counter width is clog2(LOCK_CYCLES)+1 and saturates.

Optional Feature:
- Macro: CLKGEN_PHASE_EN.
- Defined:
  - PHASE regs exist.
  - On restart a channel's counter starts at (N - P) mod N, so its first ce and rising edge occur at edge k+1+P (P=0 → edge k+1).
- Undefined:
  - PHASE regs absent; writes to reg 2 are ignored; reg 2 reads 0.
  - Counters always start at 0.

Test Plan:
- Reset release, defaults (DEFAULT_DIV=4) → all outclk 1100 pattern, period 4 cycles, ce at edge 1,5,9; locked rises at edge 256.
- Write ch1 DIV=10, HIGH=3, then apply → ch1 high 3 / low 7 cycles; locked low for exactly 256 cycles after apply; other channels re-aligned to the apply edge.
- Invalid config ch0 DIV=1, HIGH=0, apply → active N=2, H=1, outclk toggles every cycle; reading reg 0 returns 1 (shadow raw), rvalid one cycle after rd.
- apply asserted while locked, and again at cycle 100 of relock → locked rises 256 cycles after the second apply only.
- CLKGEN_PHASE_EN: ch2 DIV=8, PHASE=3 vs ch0 DIV=8, PHASE=0 → ch2 ce exactly 3 cycles after ch0 ce; PHASE=11 behaves as 3. Without the macro, ch2 ce is coincident with ch0 ce.
- Async rst asserted mid-period → outclk, ce, locked go 0 immediately (no clock edge); shadow returns to defaults.
